// File: rtl/alu_op_decoder.sv
// Registered RV32I decode/issue stage for alu_i: 1-cycle accept-to-output latency, valid/ready on both sides.
// Optional ALU_DEC_SKID_EN adds a skid entry so In_ready is registered; otherwise In_ready follows Out_ready combinationally.
module alu_op_decoder #(
  parameter int         XLEN     = 32,
  parameter logic [3:0] NOP_CODE = 4'd7
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Flush,
  input  logic            In_valid,
  output logic            In_ready,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] Pc,
  input  logic [XLEN-1:0] Rs1_data,
  input  logic [XLEN-1:0] Rs2_data,
  output logic            Out_valid,
  input  logic            Out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      Code,
  output logic            Sel,
  output logic [4:0]      Rd,
  output logic            Rd_we,
  output logic            Illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] CODE_ADD  = 4'd0;
  localparam logic [3:0] CODE_SHL  = 4'd1;
  localparam logic [3:0] CODE_SHR  = 4'd2;
  localparam logic [3:0] CODE_XOR  = 4'd3;
  localparam logic [3:0] CODE_OR   = 4'd4;
  localparam logic [3:0] CODE_AND  = 4'd5;
  localparam logic [3:0] CODE_COMP = 4'd6;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      code;
    logic            sel;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } slot_t;

  localparam slot_t SLOT_RST = '{a: '0, b: '0, code: NOP_CODE, sel: 1'b0,
                                 rd: 5'd0, rd_we: 1'b0, illegal: 1'b0};

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_base;
  logic       f7_alt;
  logic       legal;
  logic [3:0] alu_code;
  slot_t      dec;

  assign opcode  = Instr[6:0];
  assign funct3  = Instr[14:12];
  assign funct7  = Instr[31:25];
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  always_comb begin
    alu_code = CODE_ADD;
    case (funct3)
      3'b000:  alu_code = CODE_ADD;
      3'b001:  alu_code = CODE_SHL;
      3'b010:  alu_code = CODE_COMP;
      3'b011:  alu_code = CODE_COMP;
      3'b100:  alu_code = CODE_XOR;
      3'b101:  alu_code = CODE_SHR;
      3'b110:  alu_code = CODE_OR;
      default: alu_code = CODE_AND;
    endcase
  end

  always_comb begin
    legal       = 1'b0;
    dec         = SLOT_RST;
    dec.rd      = Instr[11:7];
    case (opcode)
      OPC_OP: begin
        // Only SUB and SRA may carry the alternate funct7.
        legal    = f7_base | (f7_alt & ((funct3 == 3'b000) | (funct3 == 3'b101)));
        dec.a    = Rs1_data;
        dec.b    = Rs2_data;
        dec.code = alu_code;
        dec.sel  = (funct3 == 3'b011) |
                   (f7_alt & ((funct3 == 3'b000) | (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.a    = Rs1_data;
        dec.code = alu_code;
        // ADDI never subtracts, so only SLTIU and SRAI raise Sel.
        dec.sel  = (funct3 == 3'b011) | ((funct3 == 3'b101) & f7_alt);
        if (funct3 == 3'b001) begin
          legal = f7_base;
          dec.b = {27'b0, Instr[24:20]};
        end else if (funct3 == 3'b101) begin
          legal = f7_base | f7_alt;
          dec.b = {27'b0, Instr[24:20]};
        end else begin
          legal = 1'b1;
          dec.b = {{20{Instr[31]}}, Instr[31:20]};
        end
      end
      OPC_LUI: begin
        legal    = 1'b1;
        dec.a    = '0;
        dec.b    = {Instr[31:12], 12'b0};
        dec.code = CODE_ADD;
        dec.sel  = 1'b0;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        dec.a    = Pc;
        dec.b    = {Instr[31:12], 12'b0};
        dec.code = CODE_ADD;
        dec.sel  = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // Illegal slots still flow downstream so the trap logic sees them.
    if (!legal) begin
      dec.a    = '0;
      dec.b    = '0;
      dec.code = NOP_CODE;
      dec.sel  = 1'b0;
    end
    dec.rd_we   = legal & (dec.rd != 5'd0);
    dec.illegal = ~legal;
  end

  slot_t main_q, main_d;
  logic  main_vld_q, main_vld_d;
  logic  accept;

`ifdef ALU_DEC_SKID_EN
  slot_t skid_q, skid_d;
  logic  skid_vld_q, skid_vld_d;
  logic  in_rdy_q, in_rdy_d;
  logic  take;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    take       = main_vld_q & Out_ready;
    accept     = In_valid & in_rdy_q;
    if (Flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || take) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
        if (accept) begin
          skid_d     = dec;
          skid_vld_d = 1'b1;
        end
      end else if (accept) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      skid_q     <= SLOT_RST;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign In_ready = in_rdy_q;
`else
  logic in_rdy;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    in_rdy     = ~main_vld_q | Out_ready;
    accept     = In_valid & in_rdy;
    if (Flush) begin
      main_vld_d = 1'b0;
    end else if (accept) begin
      main_d     = dec;
      main_vld_d = 1'b1;
    end else if (Out_ready) begin
      main_vld_d = 1'b0;
    end
  end

  assign In_ready = in_rdy;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      main_q     <= SLOT_RST;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end

  assign Out_valid = main_vld_q;
  assign A         = main_q.a;
  assign B         = main_q.b;
  assign Code      = main_q.code;
  assign Sel       = main_q.sel;
  assign Rd        = main_q.rd;
  assign Rd_we     = main_q.rd_we;
  assign Illegal   = main_q.illegal;

endmodule
